bcd_time_core: RTL
==================

Name: bcd_time_core

Overview:
- Free-running time-of-day counter that consumes the committed BCD time word and load strobe from the time-configuration stage.
- Keeps hh:mm:ss in packed BCD on a prescaled 1 Hz tick.
- Feeds the display stage with the current time and an update strobe.
- Validates loaded values, because the configuration stage increments digits without range checks.

Parameters:
- CLK_DIV, 50000000: system clock cycles per second tick; must be >= 2.
- DIV_W, 26: prescaler counter width; must satisfy 2^DIV_W >= CLK_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load_req  in  1  single-cycle strobe; commit load_time
- load_time  in  24  {hh, mm, ss}, packed BCD, two digits each
- run_en  in  1  1 = count, 0 = hold time (prescaler also holds)
- time_bcd  out  24  current {hh, mm, ss} BCD
- time_upd  out  1  one-cycle pulse whenever time_bcd changes
- min_wrap  out  1  one-cycle pulse on ss 59->00
- hour_wrap  out  1  one-cycle pulse on mm 59->00 together with ss wrap
- day_wrap  out  1  one-cycle pulse on 23:59:59->00:00:00
- load_ack  out  1  one-cycle pulse; load accepted
- load_err  out  1  one-cycle pulse; load rejected

Behaviour:
- Reset (async assert, sync release): time_bcd=24'h000000; prescaler=0; all pulse outputs=0.
- Prescaler:
  - counts 0..CLK_DIV-1 while run_en=1.
  - The tick fires in the cycle it equals CLK_DIV-1, then it wraps to 0.
  - run_en=0 freezes both the prescaler and the time.
- Tick cascade (all in the same edge):
  - ss += 1 in BCD.
  - At ss=59: ss->00, mm += 1, min_wrap=1.
  - At mm=59 with ss wrap: mm->00, hh += 1, hour_wrap=1.
  - At hh=23 with mm and ss wrap: hh->00, day_wrap=1.
- BCD rule: when a low digit is 9, it goes to 0 and the high digit increments. Values such as 0x3A never occur in time_bcd.
- Load validity: every nibble <= 9, ss <= 0x59, mm <= 0x59, hh <= 0x23.
- Valid load:
  - time_bcd <= load_time on the next edge.
  - The prescaler is cleared to 0, so the first tick after a load comes CLK_DIV cycles later.
  - load_ack=1 and time_upd=1 in that cycle.
- Invalid load: time_bcd and the prescaler are unchanged; load_err=1; no time_upd.
- Load and tick in the same cycle: the load wins and the tick is discarded. No wrap pulses fire even if the old time was 23:59:59.
- Loads are accepted regardless of run_en.
- time_upd: asserted on every tick edge (run_en=1) and on every valid load. Registered; aligned with the new time_bcd value.
- Output timing: all outputs are registered; time_bcd changes exactly one edge after the tick or load_req cycle.
- Reset mid-count or mid-load: state clears immediately; a load_req coincident with rst is ignored.

Decomposition:
- Shared package (clock_pkg):
  - constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23, TIME_ZERO=24'h000000
  - BCD field offsets SS_LSB=0, MM_LSB=8, HH_LSB=16
  - a bcd_valid check, usable also by the display stage
- Sub-module bcd_pair_counter:
  - two-digit BCD counter with en, max value input, wrap output and a parallel load port.
  - bcd_time_core instantiates three of them, chained on wrap.
- The prescaler and load validator stay inline.

Test Plan (CLK_DIV=4):
- Reset, run_en=1, 12 cycles -> time_bcd 000000 -> 000001 -> 000002 -> 000003, one update every 4 cycles; time_upd pulses each time.
- Load 235958, then 2 ticks -> 235959, then 000000 with min_wrap, hour_wrap and day_wrap all 1 for one cycle; load_ack pulses once.
- Load 0x12_3A_05 (illegal nibble) and 0x24_00_00 (hour > 23) -> load_err pulses each time; time_bcd unchanged; no time_upd.
- Load 095959 in the exact tick cycle of a running 000007 -> time_bcd=095959; no wrap pulses; next tick lands 4 cycles later -> 100000 with min_wrap and hour_wrap.
- run_en=0 for 20 cycles at 000009 -> no change and no pulses; after re-enable, the next tick lands after the remaining prescaler count -> 000010 with no min_wrap.
- Assert rst mid-count at 150430 -> time_bcd=000000 immediately (async); after release the first tick comes 4 cycles later.

Source files
------------

// File: rtl/bcd_time_core_pkg.sv
// Shared time-of-day constants, BCD field offsets and the load validity check.
// Latency: n/a (package only).
// Backpressure: n/a.
package clock_pkg;

  localparam logic [7:0]  SEC_MAX   = 8'h59;
  localparam logic [7:0]  MIN_MAX   = 8'h59;
  localparam logic [7:0]  HOUR_MAX  = 8'h23;
  localparam logic [23:0] TIME_ZERO = 24'h000000;

  localparam int SS_LSB = 0;
  localparam int MM_LSB = 8;
  localparam int HH_LSB = 16;

  // True when every nibble is a decimal digit and each field is within its range.
  // Byte compares against BCD limits are only meaningful once the nibbles are known
  // to be decimal, which is why both conditions are combined here.
  function automatic logic bcd_valid(input logic [23:0] t);
    logic digits_ok;
    digits_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
    return digits_ok &&
           (t[SS_LSB +: 8] <= SEC_MAX) &&
           (t[MM_LSB +: 8] <= MIN_MAX) &&
           (t[HH_LSB +: 8] <= HOUR_MAX);
  endfunction

endpackage

// File: rtl/bcd_time_core_pair_counter.sv
// Two-digit packed-BCD counter with parallel load; wraps to 00 after max_i.
// Latency: value updates one edge after en_i/load_i; wrap_o is combinational.
// Backpressure: none; load_i overrides en_i.
module bcd_pair_counter
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [7:0] max_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] val_o,
  output logic       wrap_o
);

  logic [7:0] val_q, val_d;

  // Increment in BCD: low digit rolls 9->0 and carries into the high digit.
  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = load_val_i;
    end else if (en_i) begin
      if (val_q == max_i) begin
        val_d = 8'h00;
      end else if (val_q[3:0] == 4'd9) begin
        val_d = {val_q[7:4] + 4'd1, 4'd0};
      end else begin
        val_d = {val_q[7:4], val_q[3:0] + 4'd1};
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= TIME_ZERO[7:0];
    else     val_q <= val_d;
  end

  assign val_o  = val_q;
  // A load in the same cycle suppresses the carry so no wrap pulse escapes.
  assign wrap_o = en_i && !load_i && (val_q == max_i);

endmodule

// File: rtl/bcd_time_core.sv
// Free-running hh:mm:ss BCD clock with prescaled tick, validated load and wrap pulses.
// Latency: every output registered; time_bcd changes one edge after tick/load cycle.
// Backpressure: none; a valid load wins over a coincident tick, run_en=0 freezes all.
module bcd_time_core
  import clock_pkg::*;
#(
  parameter int CLK_DIV = 50000000,
  parameter int DIV_W   = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic [23:0] load_time,
  input  logic        run_en,
  output logic [23:0] time_bcd,
  output logic        time_upd,
  output logic        min_wrap,
  output logic        hour_wrap,
  output logic        day_wrap,
  output logic        load_ack,
  output logic        load_err
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick, load_ok, do_load, sec_en;
  logic             ss_wrap, mm_wrap, hh_wrap;
  logic [7:0]       ss_val, mm_val, hh_val;
  logic             upd_q, minw_q, hourw_q, dayw_q, ack_q, err_q;

  assign tick    = run_en && (div_q == DIV_LAST);
  assign load_ok = bcd_valid(load_time);
  assign do_load = load_req && load_ok;
  assign sec_en  = tick && !do_load;

  // Prescaler: cleared by an accepted load, otherwise counts 0..CLK_DIV-1 while running.
  always_comb begin
    div_d = div_q;
    if (do_load)        div_d = '0;
    else if (tick)      div_d = '0;
    else if (run_en)    div_d = div_q + DIV_W'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  bcd_pair_counter u_ss (
    .clk        (clk),
    .rst        (rst),
    .en_i       (sec_en),
    .max_i      (SEC_MAX),
    .load_i     (do_load),
    .load_val_i (load_time[SS_LSB +: 8]),
    .val_o      (ss_val),
    .wrap_o     (ss_wrap)
  );

  bcd_pair_counter u_mm (
    .clk        (clk),
    .rst        (rst),
    .en_i       (ss_wrap),
    .max_i      (MIN_MAX),
    .load_i     (do_load),
    .load_val_i (load_time[MM_LSB +: 8]),
    .val_o      (mm_val),
    .wrap_o     (mm_wrap)
  );

  bcd_pair_counter u_hh (
    .clk        (clk),
    .rst        (rst),
    .en_i       (mm_wrap),
    .max_i      (HOUR_MAX),
    .load_i     (do_load),
    .load_val_i (load_time[HH_LSB +: 8]),
    .val_o      (hh_val),
    .wrap_o     (hh_wrap)
  );

  // Pulse outputs, registered so they line up with the new time value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_q   <= 1'b0;
      minw_q  <= 1'b0;
      hourw_q <= 1'b0;
      dayw_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      upd_q   <= do_load || sec_en;
      minw_q  <= ss_wrap;
      hourw_q <= mm_wrap;
      dayw_q  <= hh_wrap;
      ack_q   <= do_load;
      err_q   <= load_req && !load_ok;
    end
  end

  assign time_bcd  = {hh_val, mm_val, ss_val};
  assign time_upd  = upd_q;
  assign min_wrap  = minw_q;
  assign hour_wrap = hourw_q;
  assign day_wrap  = dayw_q;
  assign load_ack  = ack_q;
  assign load_err  = err_q;

endmodule
